// File: rtl/bscac7_pkg.sv
// Shared types and constants for the BSCAC7 encoder front end.
// bscac7_next_word forms the next TSV codeword from the lane heads and read-enables.
package bscac7_pkg;

    localparam int BSCAC7_WIRES    = 7;
    localparam int BSCAC7_DTSV_IDX = 0;

    typedef logic [0:6] bscac7_word_t;

    // DTSV always takes its head; a locked STSV keeps its current level.
    function automatic bscac7_word_t bscac7_next_word(input bscac7_word_t head,
                                                      input bscac7_word_t state,
                                                      input logic [1:6]   ctrl);
        bscac7_word_t w;
        w = state;
        w[BSCAC7_DTSV_IDX] = head[BSCAC7_DTSV_IDX];
        for (int k = 1; k <= 6; k++) begin
            if (ctrl[k]) begin
                w[k] = head[k];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bscac7_lane_fifo.sv
// One-bit-wide lane FIFO with a registered head.
// When empty, the head holds the last popped bit, or 0 after reset.
module bscac7_lane_fifo #(
    parameter int unsigned  DEPTH = 8,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            din,
    output logic            head,
    output logic [CntW-1:0] count,
    output logic            full,
    output logic            empty
);

    logic [DEPTH-1:0] mem_q;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CntW-1:0]  count_q, count_d, kept;
    logic             head_q, head_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = head_q;
    assign count   = count_q;

    always_comb begin
        kept       = count_q - CntW'(do_pop);
        count_d    = kept + CntW'(do_push);
        rd_ptr_nxt = rd_ptr_q + PtrW'(do_pop);
        head_d     = head_q;
        // With no surviving old entry, the new head is the word being written now.
        if (kept != '0) begin
            head_d = mem_q[rd_ptr_nxt];
        end else if (do_push) begin
            head_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PtrW'(do_push);
            rd_ptr_q <= rd_ptr_nxt;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/bscac7_lane_buffer.sv
// BSCAC7 encoder front end: seven lane FIFOs feeding the TSV state register.
// A codeword advances only when every lane holds a symbol.
module bscac7_lane_buffer
    import bscac7_pkg::*;
#(
    parameter int unsigned  DEPTH = 8,
    localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:6]           in_data,
    output logic [0:6]           data_2b_trans,
    output logic [0:6]           stsvs_state_current,
    input  logic [1:6]           ctrl_signals,
    output logic                 out_valid,
    output logic [1:6][CntW-1:0] lane_count
);

    logic [0:6]      full, empty, pop;
    logic [CntW-1:0] count [0:6];
    logic            push, adv;
    bscac7_word_t    state_q, state_d;
    logic            out_valid_q;
    logic            unused_dtsv_count;

    assign in_ready = rst_n & ~|full;
    assign push     = in_valid & in_ready;
    assign adv      = ~|empty;

    always_comb begin
        pop = '0;
        pop[BSCAC7_DTSV_IDX] = adv;
        for (int k = 1; k <= 6; k++) begin
            pop[k] = adv & ctrl_signals[k];
        end
    end

    for (genvar i = 0; i < BSCAC7_WIRES; i++) begin : g_lane
        bscac7_lane_fifo #(
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .push (push),
            .pop  (pop[i]),
            .din  (in_data[i]),
            .head (data_2b_trans[i]),
            .count(count[i]),
            .full (full[i]),
            .empty(empty[i])
        );
    end

    // Lane 0 occupancy is not exported; it can never exceed the STSV lanes.
    assign unused_dtsv_count = ^count[BSCAC7_DTSV_IDX];

    always_comb begin
        for (int k = 1; k <= 6; k++) begin
            lane_count[k] = count[k];
        end
    end

    always_comb begin
        state_d = state_q;
        if (adv) begin
            state_d = bscac7_next_word(data_2b_trans, state_q, ctrl_signals);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= adv;
        end
    end

    assign stsvs_state_current = state_q;
    assign out_valid           = out_valid_q;

endmodule

// File: tb/tb_bscac7_lane_buffer.sv
// Directed and randomized checks of bscac7_lane_buffer against a queue-based lane model.
module tb_bscac7_lane_buffer;

    localparam int DEPTH = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [0:6]      in_data;
    logic [0:6]      data_2b_trans;
    logic [0:6]      stsvs_state_current;
    logic [1:6]      ctrl_signals;
    logic            out_valid;
    logic [1:6][3:0] lane_count;

    int tests_run;
    int tests_failed;

    bit         lq [7][$];
    bit         last_pop [7];
    logic [0:6] m_state;
    logic       m_ov;

    bscac7_lane_buffer #(
        .DEPTH(DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .data_2b_trans      (data_2b_trans),
        .stsvs_state_current(stsvs_state_current),
        .ctrl_signals       (ctrl_signals),
        .out_valid          (out_valid),
        .lane_count         (lane_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 7; i++) begin
            lq[i].delete();
            last_pop[i] = 1'b0;
        end
        m_state = '0;
        m_ov    = 1'b0;
    endtask

    function automatic bit model_ready();
        for (int i = 0; i < 7; i++) begin
            if (lq[i].size() >= DEPTH) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit model_adv();
        for (int i = 0; i < 7; i++) begin
            if (lq[i].size() == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_state"}, 32'(stsvs_state_current), 32'(m_state));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(m_ov));
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("%s_count%0d", tag, k), 32'(lane_count[k]), 32'(lq[k].size()));
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cycle(input logic v, input logic [0:6] d, input logic [1:6] c);
        bit         rdy, adv;
        logic [0:6] heads, nxt;
        in_valid     = v;
        in_data      = d;
        ctrl_signals = c;
        #1;
        rdy = model_ready();
        adv = model_adv();
        for (int i = 0; i < 7; i++) begin
            heads[i] = (lq[i].size() != 0) ? lq[i][0] : last_pop[i];
        end
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("heads", 32'(data_2b_trans), 32'(heads));
        if (adv) begin
            for (int i = 0; i < 7; i++) begin
                if (i == 0 || c[i]) begin
                    last_pop[i] = lq[i].pop_front();
                    nxt[i]      = last_pop[i];
                end else begin
                    nxt[i] = m_state[i];
                end
            end
            m_state = nxt;
        end
        m_ov = adv;
        if (v && rdy) begin
            for (int i = 0; i < 7; i++) lq[i].push_back(d[i]);
        end
        @(posedge clk);
        #1;
        check_regs("step");
    endtask

    // Asynchronous reset asserted mid-cycle; returns at posedge+1 after release.
    task automatic apply_reset(input int n);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check_regs("rst");
        repeat (n) @(posedge clk);
        #3;
        check("rst_hold_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int n = 0; n < DEPTH; n++) cycle(1'b1, 7'($urandom), 6'b000000);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_count", 32'(lane_count[4]), 32'(DEPTH));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        ctrl_signals = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check_regs("reset");
        #2;
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single symbol, full pop.
        cycle(1'b1, 7'b1010101, 6'b111111);
        cycle(1'b0, 7'b0000000, 6'b111111);
        check("single_state", 32'(stsvs_state_current), 32'(7'b1010101));
        check("single_ov", 32'(out_valid), 32'd1);
        cycle(1'b0, 7'b0000000, 6'b111111);
        check("single_ov_pulse", 32'(out_valid), 32'd0);

        // Locked lanes.
        apply_reset(2);
        cycle(1'b1, 7'b1111111, 6'b000000);
        cycle(1'b0, 7'b0000000, 6'b000000);
        check("lock_state", 32'(stsvs_state_current), 32'(7'b1000000));
        check("lock_count", 32'(lane_count[2]), 32'd1);
        cycle(1'b1, 7'b0000000, 6'b111111);
        cycle(1'b0, 7'b0000000, 6'b111111);
        check("unlock_state", 32'(stsvs_state_current), 32'(7'b0111111));
        check("unlock_count", 32'(lane_count[6]), 32'd1);
        cycle(1'b0, 7'b0000000, 6'b000000);

        // Fill; a ninth request is ignored and locked lanes stay full.
        apply_reset(1);
        fill();
        cycle(1'b1, 7'b1111111, 6'b000000);
        check("ninth_count", 32'(lane_count[1]), 32'(DEPTH));

        // Refill, then drain one entry with in_valid held.
        apply_reset(1);
        fill();
        cycle(1'b1, 7'b1111111, 6'b111111);
        check("drain_count", 32'(lane_count[3]), 32'(DEPTH - 1));
        check("drain_in_ready", 32'(in_ready), 32'd1);

        // Build count 5 and state 0110011, then reset asynchronously.
        apply_reset(1);
        cycle(1'b1, 7'b0110011, 6'b000000);
        cycle(1'b1, 7'($urandom) & 7'b0111111, 6'b111111);
        for (int n = 0; n < 4; n++) cycle(1'b1, 7'($urandom) & 7'b0111111, 6'b000000);
        check("mid_state", 32'(stsvs_state_current), 32'(7'b0110011));
        check("mid_count", 32'(lane_count[5]), 32'd5);
        apply_reset(1);

        // Randomized traffic; a deadlocked or randomly chosen cycle triggers reset.
        for (int n = 0; n < 1500; n++) begin
            if ((!model_ready() && !model_adv()) || ($urandom_range(0, 199) == 0)) begin
                apply_reset(int'($urandom_range(1, 3)));
            end else begin
                cycle(1'($urandom_range(0, 3) != 0), 7'($urandom), 6'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
